// File: rtl/axil_blockmem_pkg.sv
// Shared types and constants for the AXI-Lite to block-memory port.
// Holds the FSM state encoding and the AXI response codes.
package axil_blockmem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MWR,
        BRESP,
        MRD,
        RWAIT,
        RRESP
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axil_blockmem_port.sv
// AXI-Lite slave that serves one transaction at a time
// from one port of a synchronous dual-port block memory.
module axil_blockmem_port
    import axil_blockmem_pkg::*;
#(
    parameter int G_MEMWIDTH = 32,
    parameter int G_MEMDEPTH = 1024,
    parameter int G_AXI_AW   = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [G_AXI_AW-1:0]           s_awaddr,
    input  logic                          s_awvalid,
    output logic                          s_awready,
    input  logic [G_MEMWIDTH-1:0]         s_wdata,
    input  logic [G_MEMWIDTH/8-1:0]       s_wstrb,
    input  logic                          s_wvalid,
    output logic                          s_wready,
    output logic [1:0]                    s_bresp,
    output logic                          s_bvalid,
    input  logic                          s_bready,
    input  logic [G_AXI_AW-1:0]           s_araddr,
    input  logic                          s_arvalid,
    output logic                          s_arready,
    output logic [G_MEMWIDTH-1:0]         s_rdata,
    output logic [1:0]                    s_rresp,
    output logic                          s_rvalid,
    input  logic                          s_rready,
    output logic                          mem_en,
    output logic [G_MEMWIDTH/8-1:0]       mem_we,
    output logic [$clog2(G_MEMDEPTH)-1:0] mem_addr,
    output logic [G_MEMWIDTH-1:0]         mem_din,
    input  logic [G_MEMWIDTH-1:0]         mem_dout
);

    localparam int C_NB  = G_MEMWIDTH / 8;
    localparam int C_LSB = $clog2(C_NB);
    localparam int C_AW  = $clog2(G_MEMDEPTH);
    localparam logic [G_AXI_AW:0] C_LIMIT =
        (G_AXI_AW + 1)'(G_MEMDEPTH * C_NB);

    state_t                r_state;
    state_t                w_next;
    logic                  r_last_wr;
    logic [C_AW-1:0]       r_addr;
    logic [G_MEMWIDTH-1:0] r_wdata;
    logic [C_NB-1:0]       r_wstrb;
    logic [1:0]            r_bresp;
    logic [1:0]            r_rresp;
    logic [G_MEMWIDTH-1:0] r_rdata;

    logic w_idle;
    logic w_wr_elig;
    logic w_rd_elig;
    logic w_grant_wr;
    logic w_grant_rd;
    logic w_aw_oor;
    logic w_ar_oor;

    // Extra top bit so a limit equal to 2**G_AXI_AW still compares correctly
    assign w_aw_oor = {1'b0, s_awaddr} >= C_LIMIT;
    assign w_ar_oor = {1'b0, s_araddr} >= C_LIMIT;

    assign w_idle     = (r_state == IDLE) && rst_n;
    assign w_wr_elig  = s_awvalid && s_wvalid;
    assign w_rd_elig  = s_arvalid;
    assign w_grant_wr = w_idle && w_wr_elig
                        && (!w_rd_elig || !r_last_wr);
    assign w_grant_rd = w_idle && w_rd_elig && !w_grant_wr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_grant_wr) begin
                    w_next = w_aw_oor ? BRESP : MWR;
                end else if (w_grant_rd) begin
                    w_next = w_ar_oor ? RRESP : MRD;
                end
            end
            MWR:   w_next = BRESP;
            BRESP: if (s_bready) w_next = IDLE;
            MRD:   w_next = RWAIT;
            RWAIT: w_next = RRESP;
            RRESP: if (s_rready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_wr <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bresp   <= RESP_OKAY;
            r_rresp   <= RESP_OKAY;
            r_rdata   <= '0;
        end else begin
            if (w_grant_wr) begin
                r_last_wr <= 1'b1;
                r_addr    <= s_awaddr[C_LSB +: C_AW];
                r_wdata   <= s_wdata;
                r_wstrb   <= s_wstrb;
                r_bresp   <= w_aw_oor ? RESP_SLVERR : RESP_OKAY;
            end
            if (w_grant_rd) begin
                r_last_wr <= 1'b0;
                r_addr    <= s_araddr[C_LSB +: C_AW];
                r_rresp   <= w_ar_oor ? RESP_SLVERR : RESP_OKAY;
                r_rdata   <= '0;
            end
            if (r_state == RWAIT) begin
                r_rdata <= mem_dout;
            end
        end
    end

    // Memory strobes are gated by rst_n so a reset mid-access cannot leak a pulse
    always_comb begin
        s_awready = w_grant_wr;
        s_wready  = w_grant_wr;
        s_arready = w_grant_rd;
        s_bvalid  = (r_state == BRESP);
        s_bresp   = r_bresp;
        s_rvalid  = (r_state == RRESP);
        s_rresp   = r_rresp;
        s_rdata   = r_rdata;
        mem_en    = 1'b0;
        mem_we    = '0;
        mem_addr  = '0;
        mem_din   = '0;
        if (rst_n && (r_state == MWR)) begin
            mem_en   = 1'b1;
            mem_we   = r_wstrb;
            mem_addr = r_addr;
            mem_din  = r_wdata;
        end
        if (rst_n && (r_state == MRD)) begin
            mem_en   = 1'b1;
            mem_addr = r_addr;
        end
    end

endmodule

// File: tb/tb_axil_blockmem_port.sv
// Randomized bench for axil_blockmem_port against a
// word-array reference model with a block-RAM stand-in.
module tb_axil_blockmem_port;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] s_awaddr;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wvalid;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready;
    logic [15:0] s_araddr;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    axil_blockmem_port dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_awaddr  (s_awaddr),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_bresp   (s_bresp),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .s_araddr  (s_araddr),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout)
    );

    always #5 clk = ~clk;

    logic [31:0] bram    [1024];
    logic [31:0] ref_mem [1024];
    logic [31:0] w_merge;
    int          en_cnt = 0;
    logic [9:0]  last_addr = '0;
    logic [3:0]  last_we = '0;
    logic [31:0] last_din = '0;
    int          n_chk = 0;
    int          n_fail = 0;
    bit          last_wr = 1'b0;

    always_comb begin
        w_merge = bram[mem_addr];
        for (int b = 0; b < 4; b++) begin
            if (mem_we[b]) w_merge[8*b +: 8] = mem_din[8*b +: 8];
        end
    end

    always @(posedge clk) begin
        if (mem_en) begin
            if (|mem_we) bram[mem_addr] <= w_merge;
            mem_dout <= bram[mem_addr];
        end
    end

    always @(negedge clk) begin
        if (mem_en) begin
            en_cnt    <= en_cnt + 1;
            last_addr <= mem_addr;
            last_we   <= mem_we;
            last_din  <= mem_din;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
        input logic [31:0] new_w, input logic [3:0] strb);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic [23:0] ctrl_outs();
        return {s_awready, s_wready, s_arready, s_bvalid, s_rvalid,
                s_bresp, s_rresp, mem_en, mem_we, mem_addr};
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0;
        s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
        s_bready = 0; s_rready = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ctrl", 64'(ctrl_outs()), 64'h0);
        chk("rst_data", {s_rdata, mem_din}, 64'h0);
        rst_n = 1'b1;
        last_wr = 1'b0;
    endtask

    task automatic wait_hs(output bit gw, output bit gr);
        gw = 0;
        gr = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            gw = s_awready && s_wready;
            gr = s_arready;
            if (s_awready || s_wready || s_arready) begin
                chk("aw_w_pair", 64'(s_awready), 64'(s_wready));
                chk("rdy_excl", 64'(gw && gr), 64'h0);
                break;
            end
        end
        if (!gw && !gr) chk("hs_timeout", 64'h0, 64'h1);
        @(posedge clk);
        #1;
    endtask

    task automatic wr_finish(input logic [15:0] a, input logic [31:0] d,
        input logic [3:0] s, input int hold, input int en0);
        bit         inr;
        logic [1:0] er;
        int         lat;
        inr = (a < 16'h1000);
        er  = inr ? 2'b00 : 2'b10;
        for (lat = 1; lat < 20; lat++) begin
            chk("wr_busy_rdy", {s_awready, s_wready, s_arready}, 64'h0);
            if (s_bvalid) break;
            @(posedge clk);
            #1;
        end
        if (!s_bvalid) chk("b_timeout", 64'h0, 64'h1);
        chk("b_lat", 64'(lat), inr ? 64'd2 : 64'd1);
        chk("bresp", 64'(s_bresp), 64'(er));
        repeat (hold) begin
            @(posedge clk);
            #1;
            chk("b_hold", {s_bvalid, s_bresp}, {1'b1, er});
        end
        s_bready = 1'b1;
        @(posedge clk);
        #1;
        s_bready = 1'b0;
        chk("b_done", 64'(s_bvalid), 64'h0);
        chk("wr_en_cnt", 64'(en_cnt - en0), inr ? 64'd1 : 64'd0);
        if (inr) begin
            chk("wr_mem", {last_addr, last_we, last_din}, {a[11:2], s, d});
            ref_mem[a[11:2]] = byte_merge(ref_mem[a[11:2]], d, s);
        end
        last_wr = 1'b1;
    endtask

    task automatic rd_finish(input logic [15:0] a, input int hold,
                             input int en0);
        bit          inr;
        logic [1:0]  er;
        logic [31:0] ed;
        int          lat;
        inr = (a < 16'h1000);
        er  = inr ? 2'b00 : 2'b10;
        ed  = inr ? ref_mem[a[11:2]] : 32'h0;
        for (lat = 1; lat < 20; lat++) begin
            chk("rd_busy_rdy", {s_awready, s_wready, s_arready}, 64'h0);
            if (s_rvalid) break;
            @(posedge clk);
            #1;
        end
        if (!s_rvalid) chk("r_timeout", 64'h0, 64'h1);
        chk("r_lat", 64'(lat), inr ? 64'd3 : 64'd1);
        chk("rdata", {s_rresp, s_rdata}, {er, ed});
        repeat (hold) begin
            @(posedge clk);
            #1;
            chk("r_hold", {s_rvalid, s_rresp, s_rdata}, {1'b1, er, ed});
        end
        s_rready = 1'b1;
        @(posedge clk);
        #1;
        s_rready = 1'b0;
        chk("r_done", 64'(s_rvalid), 64'h0);
        chk("rd_en_cnt", 64'(en_cnt - en0), inr ? 64'd1 : 64'd0);
        if (inr) chk("rd_mem", {last_addr, last_we}, {a[11:2], 4'h0});
        last_wr = 1'b0;
    endtask

    task automatic do_wr(input logic [15:0] a, input logic [31:0] d,
                         input logic [3:0] s, input int hold);
        int en0;
        bit gw, gr;
        en0 = en_cnt;
        s_awaddr = a; s_wdata = d; s_wstrb = s;
        s_awvalid = 1; s_wvalid = 1;
        wait_hs(gw, gr);
        s_awvalid = 0; s_wvalid = 0;
        chk("wr_grant", 64'(gw), 64'h1);
        wr_finish(a, d, s, hold, en0);
    endtask

    task automatic do_rd(input logic [15:0] a, input int hold);
        int en0;
        bit gw, gr;
        en0 = en_cnt;
        s_araddr = a;
        s_arvalid = 1;
        wait_hs(gw, gr);
        s_arvalid = 0;
        chk("rd_grant", 64'(gr), 64'h1);
        rd_finish(a, hold, en0);
    endtask

    task automatic cont(input logic [15:0] wa, input logic [31:0] d,
        input logic [3:0] s, input logic [15:0] ra, input int hold);
        int en0;
        bit gw, gr, exp_wr;
        exp_wr = !last_wr;
        en0 = en_cnt;
        s_awaddr = wa; s_wdata = d; s_wstrb = s; s_araddr = ra;
        s_awvalid = 1; s_wvalid = 1; s_arvalid = 1;
        wait_hs(gw, gr);
        chk("arb_first", 64'(gw), 64'(exp_wr));
        if (gw) begin
            s_awvalid = 0; s_wvalid = 0;
            wr_finish(wa, d, s, hold, en0);
            en0 = en_cnt;
            wait_hs(gw, gr);
            s_arvalid = 0;
            chk("arb_second_rd", 64'(gr), 64'h1);
            rd_finish(ra, hold, en0);
        end else begin
            s_arvalid = 0;
            rd_finish(ra, hold, en0);
            en0 = en_cnt;
            wait_hs(gw, gr);
            s_awvalid = 0; s_wvalid = 0;
            chk("arb_second_wr", 64'(gw), 64'h1);
            wr_finish(wa, d, s, hold, en0);
        end
    endtask

    task automatic rst_in_mrd();
        int en1;
        bit gw, gr;
        s_araddr = 16'h0020;
        s_arvalid = 1;
        wait_hs(gw, gr);
        s_arvalid = 0;
        chk("mrd_en", {mem_en, mem_we}, {1'b1, 4'h0});
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mrd_rst_ctrl", 64'(ctrl_outs()), 64'h0);
        chk("mrd_rst_data", {s_rdata, mem_din}, 64'h0);
        en1 = en_cnt;
        rst_n = 1'b1;
        last_wr = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            chk("mrd_no_rvalid", {s_rvalid, s_bvalid}, 64'h0);
        end
        chk("mrd_no_en", 64'(en_cnt - en1), 64'h0);
    endtask

    function automatic logic [15:0] rand_addr();
        if ($urandom_range(0, 7) == 0)
            return 16'(16'h1000 + $urandom_range(0, 16'hEFFF));
        return 16'({$urandom_range(0, 31), 2'($urandom_range(0, 3))});
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) begin
            bram[i]    = 32'h0;
            ref_mem[i] = 32'h0;
        end
        s_awaddr = 0; s_wdata = 0; s_wstrb = 0; s_araddr = 0;
        #1;
        apply_reset();

        do_wr(16'h0010, 32'hDEADBEEF, 4'hF, 0);
        do_rd(16'h0010, 0);
        do_wr(16'h0010, 32'h11223344, 4'h2, 1);
        do_rd(16'h0010, 2);
        chk("strb_merge", 64'(ref_mem[4]), 64'hDEAD33EF);
        do_rd(16'h1000, 1);
        do_wr(16'h2000, 32'hCAFEF00D, 4'hF, 2);
        do_wr(16'h0FFC, 32'h0BADCAFE, 4'hF, 0);
        do_rd(16'h0FFC, 0);
        do_wr(16'h0008, 32'hFFFFFFFF, 4'h0, 0);
        do_rd(16'h0008, 0);

        apply_reset();
        cont(16'h0040, 32'hA5A50001, 4'hF, 16'h0040, 5);
        cont(16'h0044, 32'h5A5A0002, 4'hC, 16'h0040, 5);

        rst_in_mrd();

        for (int i = 0; i < 60; i++) begin
            int op;
            op = $urandom_range(0, 2);
            if (op == 0)
                do_wr(rand_addr(), $urandom, 4'($urandom),
                      $urandom_range(0, 3));
            else if (op == 1)
                do_rd(rand_addr(), $urandom_range(0, 3));
            else
                cont(rand_addr(), $urandom, 4'($urandom), rand_addr(),
                     $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
